// File: rtl/channelizer_cfg_sequencer.sv
// Sequences FFT/averaging configuration changes and coefficient reloads for a channelizer:
// stops input, waits for the output to drain, applies the shadowed config, then streams coefficients.
module channelizer_cfg_sequencer #(
  parameter int          DRAIN_CYCLES  = 64,
  parameter int          MAX_COEFS     = 65536,
  parameter logic [11:0] FFT_SIZE_INIT = 12'd64,
  parameter logic [8:0]  AVG_LEN_INIT  = 9'd1
) (
  input  logic        ce_clk,
  input  logic        ce_rst,
  input  logic [11:0] wr_fft_size,
  input  logic        wr_fft_stb,
  input  logic [8:0]  wr_avg_len,
  input  logic        wr_avg_stb,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        ch_tvalid,
  input  logic        ch_tready,
  input  logic        out_tvalid,
  input  logic        out_tready,
  input  logic        out_tlast,
  input  logic [31:0] coef_tdata,
  input  logic        coef_tlast,
  input  logic        coef_tvalid,
  output logic        coef_tready,
  output logic [31:0] reload_tdata,
  output logic        reload_tlast,
  output logic        reload_tvalid,
  input  logic        reload_tready,
  output logic [11:0] fft_size,
  output logic [8:0]  avg_len,
  output logic        busy,
  output logic        reload_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a beat transfers on a rising ce_clk edge where valid and ready are both high;
  // valid never depends on ready, and ready may depend on valid only through pure pass-through.

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_APPLY  = 2'd2,
    ST_RELOAD = 2'd3
  } state_t;

  localparam int              IDLE_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_CYCLES - 1);
  localparam logic [16:0]     BEAT_LAST = 17'(MAX_COEFS - 1);

  state_t            state_q, state_d;
  logic [11:0]       fft_shadow_q;
  logic [8:0]        avg_shadow_q;
  logic              pend_cfg_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [16:0]       beat_cnt_q;

  logic pass, in_reload, any_stb, rl_hs, drain_done;
  logic unused_monitor;

  // The monitor's ready/last never influence sequencing.
  assign unused_monitor = &{1'b0, out_tready, out_tlast};

  assign pass       = (state_q == ST_RUN);
  assign in_reload  = (state_q == ST_RELOAD);
  assign any_stb    = wr_fft_stb | wr_avg_stb;
  assign drain_done = !out_tvalid && (idle_cnt_q == IDLE_LAST);

  assign ch_tvalid     = s_axis_tvalid & pass;
  assign s_axis_tready = ch_tready & pass;

  assign reload_tdata  = in_reload ? coef_tdata : 32'd0;
  assign reload_tvalid = in_reload & coef_tvalid;
  assign reload_tlast  = in_reload & (coef_tlast | (beat_cnt_q == BEAT_LAST));
  assign coef_tready   = in_reload & reload_tready;
  assign rl_hs         = reload_tvalid & reload_tready;

  assign busy      = !pass;
  assign dbg_state = state_q;

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // A strobe this cycle leaves RUN immediately so no beat is accepted next cycle.
      ST_RUN:    if (pend_cfg_q || any_stb || coef_tvalid) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_done) state_d = ST_APPLY;
      ST_APPLY:  state_d = coef_tvalid ? ST_RELOAD : ST_RUN;
      ST_RELOAD: if (rl_hs && reload_tlast) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      fft_shadow_q <= FFT_SIZE_INIT;
      avg_shadow_q <= AVG_LEN_INIT;
      fft_size     <= FFT_SIZE_INIT;
      avg_len      <= AVG_LEN_INIT;
      pend_cfg_q   <= 1'b0;
      idle_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      reload_err   <= 1'b0;
    end else begin
      if (wr_fft_stb) fft_shadow_q <= wr_fft_size;
      if (wr_avg_stb) avg_shadow_q <= wr_avg_len;

      // A strobe landing in APPLY keeps the request pending for another pass.
      if (any_stb)                 pend_cfg_q <= 1'b1;
      else if (state_q == ST_APPLY) pend_cfg_q <= 1'b0;

      if (state_q == ST_APPLY) begin
        fft_size <= fft_shadow_q;
        avg_len  <= avg_shadow_q;
      end

      if (state_q == ST_DRAIN && !out_tvalid && !drain_done) idle_cnt_q <= idle_cnt_q + 1'b1;
      else                                                   idle_cnt_q <= '0;

      if (!in_reload)    beat_cnt_q <= '0;
      else if (rl_hs)    beat_cnt_q <= reload_tlast ? 17'd0 : beat_cnt_q + 17'd1;

      // Forced end of a reload without source tlast means the source overran MAX_COEFS.
      if (rl_hs && reload_tlast && !coef_tlast) reload_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_channelizer_cfg_sequencer.sv
// Randomized bench for channelizer_cfg_sequencer: reload-bus scoreboard fed by a packet model,
// plus timed checks of drain/apply sequencing and reset behaviour.
module tb_channelizer_cfg_sequencer;

  localparam int          DC       = 64;
  localparam int          MC       = 8;
  localparam logic [11:0] FFT_INIT = 12'd64;
  localparam logic [8:0]  AVG_INIT = 9'd1;
  localparam logic [1:0]  ST_RUN   = 2'd0;
  localparam logic [1:0]  ST_APPLY = 2'd2;

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b1;
  logic [11:0] wr_fft_size;
  logic        wr_fft_stb;
  logic [8:0]  wr_avg_len;
  logic        wr_avg_stb;
  logic        s_axis_tvalid, s_axis_tready, ch_tvalid, ch_tready;
  logic        out_tvalid, out_tready, out_tlast;
  logic [31:0] coef_tdata;
  logic        coef_tlast, coef_tvalid, coef_tready;
  logic [31:0] reload_tdata;
  logic        reload_tlast, reload_tvalid, reload_tready;
  logic [11:0] fft_size;
  logic [8:0]  avg_len;
  logic        busy, reload_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [32:0] src_q[$];
  logic [32:0] exp_q[$];
  logic src_hs = 1'b0;
  int   beat_seen = 0;
  int   tlast_seen = 0;
  int   rdy_mode = 0;          // 0 random, 1 held low, 2 held high
  bit   force_stream = 1'b0;
  bit   exp_err = 1'b0;

  channelizer_cfg_sequencer #(
    .DRAIN_CYCLES(DC), .MAX_COEFS(MC), .FFT_SIZE_INIT(FFT_INIT), .AVG_LEN_INIT(AVG_INIT)
  ) dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst),
    .wr_fft_size(wr_fft_size), .wr_fft_stb(wr_fft_stb),
    .wr_avg_len(wr_avg_len), .wr_avg_stb(wr_avg_stb),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .ch_tvalid(ch_tvalid), .ch_tready(ch_tready),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .coef_tdata(coef_tdata), .coef_tlast(coef_tlast), .coef_tvalid(coef_tvalid), .coef_tready(coef_tready),
    .reload_tdata(reload_tdata), .reload_tlast(reload_tlast), .reload_tvalid(reload_tvalid),
    .reload_tready(reload_tready),
    .fft_size(fft_size), .avg_len(avg_len), .busy(busy), .reload_err(reload_err), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 ce_clk = ~ce_clk;
  always @(posedge ce_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ce_clk);
    #1;
  endtask

  // Reference model: a packet of n beats is split into reloads of at most MC beats,
  // each reload ending in tlast; a packet longer than MC leaves the overrun flag set.
  task automatic push_packet(input int n, input int keep);
    logic [31:0] d;
    logic        lst;
    for (int i = 0; i < n; i++) begin
      d   = $urandom();
      lst = (i == n - 1);
      src_q.push_back({lst, d});
      if (i < keep) exp_q.push_back({lst | ((i % MC) == MC - 1), d});
    end
    if (n > MC) exp_err = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge ce_clk);
      #1;
      k++;
    end while (!(src_q.size() == 0 && exp_q.size() == 0 && !busy) && k < 2000);
    check({name, "_idle_reached"}, 64'(k < 2000), 64'd1);
  endtask

  // Waits for the applied config to reach the expected value; f is the first idle drain cycle.
  task automatic wait_apply(input string name, input int f, input logic [11:0] ef, input logic [8:0] ea);
    int k;
    k = 0;
    while (!(fft_size == ef && avg_len == ea) && k < 400) begin
      @(negedge ce_clk);
      k++;
    end
    check({name, "_applied"}, 64'(k < 400), 64'd1);
    check({name, "_delay"}, 64'(cyc - f), 64'(DC + 1));
    check({name, "_pass_resumed"}, {63'd0, s_axis_tready}, {63'd0, ch_tready});
    check({name, "_not_busy"}, {63'd0, busy}, 64'd0);
  endtask

  // Driver: background random traffic and the coefficient source
  initial begin
    s_axis_tvalid = 1'b0; ch_tready = 1'b0; out_tready = 1'b0; out_tlast = 1'b0;
    coef_tvalid = 1'b0; coef_tlast = 1'b0; coef_tdata = '0; reload_tready = 1'b0;
    forever begin
      tick();
      if (src_hs && src_q.size() > 0) src_q.delete(0);
      s_axis_tvalid = force_stream ? 1'b1 : 1'($urandom_range(0, 1));
      ch_tready     = force_stream ? 1'b1 : 1'($urandom_range(0, 1));
      out_tready    = 1'($urandom_range(0, 1));
      out_tlast     = 1'($urandom_range(0, 1));
      case (rdy_mode)
        0:       reload_tready = 1'($urandom_range(0, 1));
        1:       reload_tready = 1'b0;
        default: reload_tready = 1'b1;
      endcase
      if (src_q.size() > 0) begin
        coef_tvalid = 1'b1;
        {coef_tlast, coef_tdata} = src_q[0];
      end else begin
        coef_tvalid = 1'b0;
        coef_tlast  = 1'b0;
      end
    end
  end

  // Monitor: gating relations and the reload-bus scoreboard
  initial forever begin
    @(negedge ce_clk);
    src_hs = coef_tvalid && coef_tready;
    check("ch_tvalid_gate", {63'd0, ch_tvalid}, {63'd0, s_axis_tvalid & ~busy});
    check("s_tready_gate", {63'd0, s_axis_tready}, {63'd0, ch_tready & ~busy});
    if (!busy) check("reload_quiet", {61'd0, reload_tvalid, reload_tlast, coef_tready}, 64'd0);
    if (reload_tvalid && reload_tready) begin
      beat_seen++;
      if (reload_tlast) tlast_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL reload_extra: got %0h expected no beat", {reload_tlast, reload_tdata});
      end else begin
        check("reload_beat", {31'd0, reload_tlast, reload_tdata}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int f, s, b0, t0, k, n, left;
    logic [11:0] v;
    wr_fft_size = '0; wr_fft_stb = 1'b0; wr_avg_len = '0; wr_avg_stb = 1'b0; out_tvalid = 1'b0;

    // Reset values
    repeat (3) @(negedge ce_clk);
    check("rst_fft", 64'(fft_size), 64'(FFT_INIT));
    check("rst_avg", 64'(avg_len), 64'(AVG_INIT));
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_RUN));
    check("rst_err", {63'd0, reload_err}, 64'd0);
    check("rst_reload", {61'd0, reload_tvalid, reload_tlast, coef_tready}, 64'd0);
    ce_rst = 1'b0;

    // Config write while streaming with the output still active
    force_stream = 1'b1;
    tick();
    wr_fft_size = 12'd256; wr_fft_stb = 1'b1; out_tvalid = 1'b1;
    @(negedge ce_clk);
    check("req034_ready_before", {63'd0, s_axis_tready}, 64'd1);
    tick();
    wr_fft_stb = 1'b0;
    @(negedge ce_clk);
    check("req034_ready_next", {63'd0, s_axis_tready}, 64'd0);
    check("req034_busy_next", {63'd0, busy}, 64'd1);
    repeat (10) tick();
    tick();
    out_tvalid = 1'b0; f = cyc; force_stream = 1'b0;
    wait_apply("req034", f, 12'd256, AVG_INIT);

    // Output pulses every 40 cycles hold the drain open
    v = 12'($urandom_range(512, 4095));
    tick();
    wr_fft_size = v; wr_fft_stb = 1'b1;
    tick();
    wr_fft_stb = 1'b0;
    left = 0;
    for (int p = 0; p < 5; p++) begin
      repeat (39) begin
        tick();
        out_tvalid = 1'b0;
        @(negedge ce_clk);
        if (!busy || fft_size != 12'd256) left++;
      end
      tick();
      out_tvalid = 1'b1;
      @(negedge ce_clk);
      if (!busy || fft_size != 12'd256) left++;
    end
    check("req035_held", 64'(left), 64'd0);
    tick();
    out_tvalid = 1'b0; f = cyc;
    wait_apply("req035", f, v, AVG_INIT);

    // Strobe landing in APPLY is held for a second pass
    tick();
    wr_avg_len = 9'd5; wr_avg_stb = 1'b1; s = cyc;
    tick();
    wr_avg_stb = 1'b0;
    while (cyc < s + 65) tick();
    wr_avg_len = 9'd10; wr_avg_stb = 1'b1;
    @(negedge ce_clk);
    check("req038_apply_state", 64'(dbg_state), 64'(ST_APPLY));
    tick();
    wr_avg_stb = 1'b0;
    @(negedge ce_clk);
    check("req038_first_avg", 64'(avg_len), 64'd5);
    check("req038_first_fft", 64'(fft_size), 64'(v));
    check("req038_run_between", {63'd0, busy}, 64'd0);
    wait_apply("req038_second", s + 67, v, 9'd10);

    // Eight-coefficient reload with toggling ready
    @(negedge ce_clk);
    b0 = beat_seen; t0 = tlast_seen; rdy_mode = 0;
    push_packet(8, 8);
    wait_idle("req036");
    check("req036_beats", 64'(beat_seen - b0), 64'd8);
    check("req036_tlasts", 64'(tlast_seen - t0), 64'd1);
    check("req036_err", {63'd0, reload_err}, 64'd0);

    // Random in-range reloads
    for (int r = 0; r < 3; r++) begin
      b0 = beat_seen; t0 = tlast_seen;
      rdy_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      n = $urandom_range(1, MC);
      push_packet(n, n);
      wait_idle("rand_reload");
      check("rand_beats", 64'(beat_seen - b0), 64'(n));
      check("rand_tlasts", 64'(tlast_seen - t0), 64'd1);
      check("rand_err", {63'd0, reload_err}, {63'd0, exp_err});
    end

    // Source longer than MAX_COEFS: forced tlast, overrun flag, remainder in a second reload
    b0 = beat_seen; t0 = tlast_seen; rdy_mode = 0;
    push_packet(MC + 2, MC + 2);
    wait_idle("req037");
    check("req037_beats", 64'(beat_seen - b0), 64'(MC + 2));
    check("req037_tlasts", 64'(tlast_seen - t0), 64'd2);
    check("req037_err", {63'd0, reload_err}, {63'd0, exp_err});

    // Reset in the middle of a reload
    b0 = beat_seen; t0 = tlast_seen; rdy_mode = 2;
    push_packet(8, 3);
    k = 0;
    while (beat_seen < b0 + 3 && k < 500) begin
      @(negedge ce_clk);
      #1;
      k++;
    end
    rdy_mode = 1;
    check("req039_three_beats", 64'(k < 500), 64'd1);
    repeat (3) @(negedge ce_clk);
    #1;
    check("req039_stalled", 64'(beat_seen - b0), 64'd3);
    check("req039_busy", {63'd0, busy}, 64'd1);
    check("req039_err_sticky", {63'd0, reload_err}, 64'd1);
    #2;
    ce_rst = 1'b1;
    #1;
    check("req039_state", 64'(dbg_state), 64'(ST_RUN));
    check("req039_reload", {61'd0, reload_tvalid, reload_tlast, coef_tready}, 64'd0);
    check("req039_fft", 64'(fft_size), 64'(FFT_INIT));
    check("req039_avg", 64'(avg_len), 64'(AVG_INIT));
    check("req039_err", {63'd0, reload_err}, 64'd0);
    check("req039_busy_rst", {63'd0, busy}, 64'd0);
    src_q.delete();
    exp_err = 1'b0;
    repeat (2) @(posedge ce_clk);
    @(negedge ce_clk);
    ce_rst = 1'b0; rdy_mode = 0;
    repeat (5) @(negedge ce_clk);
    #1;
    check("req039_no_tlast", 64'(tlast_seen - t0), 64'd0);
    check("req039_idle_after", {63'd0, busy}, 64'd0);

    check("final_exp_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/channelizer_cfg_sequencer.md
CHANNELIZER_CFG_SEQUENCER -- requirements
Module: channelizer_cfg_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 64: consecutive cycles with out_tvalid low before the datapath counts as drained.
REQ-002 SHALL have parameter MAX_COEFS, default 65536: maximum coefficient beats per reload.
REQ-003 SHALL have parameter FFT_SIZE_INIT, default 12'd64, and parameter AVG_LEN_INIT, default 9'd1.
REQ-004 SHALL have one clock and one reset. Reset is asynchronous and active-high.
REQ-005 ce_clk  in  1  clock.
REQ-006 ce_rst  in  1  asynchronous active-high reset.
REQ-007 wr_fft_size  in  12  requested FFT size; wr_fft_stb  in  1  write strobe.
REQ-008 wr_avg_len  in  9  requested averaging length; wr_avg_stb  in  1  write strobe.
REQ-009 s_axis_tvalid  in  1 / s_axis_tready  out  1: upstream sample handshake.
REQ-010 ch_tvalid  out  1 / ch_tready  in  1: channelizer input handshake.
REQ-011 out_tvalid  in  1 / out_tready  in  1 / out_tlast  in  1: channelizer output monitor (observe only).
REQ-012 coef_tdata  in  32 / coef_tlast  in  1 / coef_tvalid  in  1 / coef_tready  out  1: coefficient source (setting-register FIFO).
REQ-013 reload_tdata  out  32 / reload_tlast  out  1 / reload_tvalid  out  1 / reload_tready  in  1: channelizer reload bus.
REQ-014 fft_size  out  12 and avg_len  out  9: applied configuration.
REQ-015 busy  out  1 (state != RUN); reload_err  out  1 (sticky overrun flag).

Function
REQ-016 Gating SHALL be combinational: ch_tvalid = s_axis_tvalid & pass; s_axis_tready = ch_tready & pass; pass = 1 only in RUN.
REQ-017 A write strobe SHALL load its shadow register and set pend_cfg in any state; later writes overwrite the shadow (last write wins).
REQ-018 pend_coef SHALL equal coef_tvalid while in RUN.
REQ-019 FSM states: RUN, DRAIN, APPLY, RELOAD.
REQ-020 RUN -> DRAIN when pend_cfg or pend_coef. The transition SHALL be registered; no input beat is accepted after the transition edge.
REQ-021 DRAIN: idle counter clears on any cycle with out_tvalid high and increments otherwise. Go to APPLY when counter = DRAIN_CYCLES-1 with out_tvalid low.
REQ-022 APPLY, one cycle: fft_size and avg_len load from their shadows; pend_cfg clears unless a strobe occurs in the same cycle, in which case pend_cfg stays set and the new value is held in the shadow.
REQ-023 APPLY exit: to RELOAD if coef_tvalid, else to RUN.
REQ-024 RELOAD: reload_tdata = coef_tdata, reload_tvalid = coef_tvalid, coef_tready = reload_tready, combinational pass-through.
REQ-025 RELOAD: beat counter (17 bits) increments on each handshake.
REQ-026 RELOAD: reload_tlast = coef_tlast OR (count = MAX_COEFS-1).
REQ-027 RELOAD -> RUN on a handshake with reload_tlast high. If the forced tlast fired without coef_tlast, reload_err SHALL set, and the remaining source beats are left for a later reload.
REQ-028 Outside RELOAD: reload_tvalid = 0, reload_tlast = 0, coef_tready = 0.
REQ-029 A pend_cfg set during RELOAD SHALL cause RUN -> DRAIN on the cycle after the RELOAD exit.
REQ-030 Output monitor signals SHALL NOT backpressure; out_tready and out_tlast are informational only.

Reset
REQ-031 On ce_rst assertion, immediately: state = RUN, fft_size = FFT_SIZE_INIT, avg_len = AVG_LEN_INIT, shadows = init values, pend_cfg = 0, counters = 0, reload_err = 0, reload outputs low.
REQ-032 Reset asserted mid-RELOAD SHALL abandon the transfer; no tlast is emitted.
REQ-033 reload_err SHALL clear only on reset.

Verification
REQ-034 wr_fft_stb with 12'd256 while streaming -> s_axis_tready low the next cycle; fft_size = 256 exactly DRAIN_CYCLES+1 cycles after out_tvalid last fell; pass resumes the cycle after APPLY.
REQ-035 out_tvalid pulses every 40 cycles during DRAIN with DRAIN_CYCLES = 64 -> state never leaves DRAIN; pulses stop -> APPLY after 64 idle cycles.
REQ-036 Reload of 8 coefficients, tlast on beat 8, reload_tready toggling -> exactly 8 beats on the reload bus, tlast on beat 8 only, busy low afterwards, reload_err = 0.
REQ-037 MAX_COEFS = 4 with a source of 6 beats -> reload_tlast on beat 4, reload_err = 1, then a second RELOAD carries beats 5-6.
REQ-038 wr_avg_stb with 9'd10 in the APPLY cycle, after an earlier 9'd5 -> avg_len = 5 first, then a second DRAIN/APPLY yields 10.
REQ-039 ce_rst pulse mid-RELOAD after 3 beats -> all outputs return to reset values within the same cycle; state = RUN; no tlast is observed.
